// File: rtl/ysyx_22050243_load_unit.sv
// Load formatter: issues a doubleword-aligned read, then extracts and extends the addressed field.
// Optional alignment fault check enabled by defining YSYX_22050243_LOAD_ALIGN_CHECK_EN.
module ysyx_22050243_load_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [2:0]       ld_funct3,
  input  logic [4:0]       ld_rd,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [WIDTH-1:0] mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             wb_fault,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e           state_q;
  logic             ld_ready_q, busy_q, req_valid_q, wb_valid_q;
  logic [WIDTH-1:0] req_addr_q, wb_data_q;
  logic [4:0]       wb_rd_q;
  logic [2:0]       off_q, f3_q;
  logic [WIDTH-1:0] shifted, fmt_d;

  always_comb shifted = mem_resp_data >> {off_q, 3'b000};

  always_comb begin
    fmt_d = shifted;
    case (f3_q)
      3'b000:  fmt_d = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  fmt_d = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b010:  fmt_d = {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
      3'b100:  fmt_d = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  fmt_d = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      3'b110:  fmt_d = {{(WIDTH-32){1'b0}}, shifted[31:0]};
      default: fmt_d = shifted;
    endcase
  end

`ifdef YSYX_22050243_LOAD_ALIGN_CHECK_EN
  logic misalign;
  logic fault_q;

  always_comb begin
    misalign = 1'b0;
    case (ld_funct3)
      3'b001, 3'b101: misalign = ld_addr[0];
      3'b010, 3'b110: misalign = |ld_addr[1:0];
      3'b011:         misalign = |ld_addr[2:0];
      3'b111:         misalign = 1'b1;
      default:        misalign = 1'b0;
    endcase
  end

  assign wb_fault = fault_q;
`else
  assign wb_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ld_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      req_addr_q  <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      off_q       <= '0;
      f3_q        <= '0;
`ifdef YSYX_22050243_LOAD_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (ld_valid && ld_ready_q) begin
          req_addr_q <= {ld_addr[WIDTH-1:3], 3'b000};
          off_q      <= ld_addr[2:0];
          f3_q       <= ld_funct3;
          wb_rd_q    <= ld_rd;
          ld_ready_q <= 1'b0;
          busy_q     <= 1'b1;
`ifdef YSYX_22050243_LOAD_ALIGN_CHECK_EN
          // Faulting loads skip memory entirely and report in the next cycle.
          fault_q <= misalign;
          if (misalign) begin
            wb_data_q  <= '0;
            wb_valid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
`else
          req_valid_q <= 1'b1;
          state_q     <= REQ;
`endif
        end
        REQ: if (mem_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (mem_resp_valid) begin
          wb_data_q  <= fmt_d;
          wb_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: if (wb_ready) begin
          wb_valid_q <= 1'b0;
          ld_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ld_ready      = ld_ready_q;
  assign busy          = busy_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_ysyx_22050243_load_unit.sv
// Scoreboard bench for the load unit: driver, memory responder, writeback sink and monitor run independently.
module tb_ysyx_22050243_load_unit;

  logic        clk, rst;
  logic        ld_valid, ld_ready;
  logic [63:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_fault, busy;

  ysyx_22050243_load_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_fault(wb_fault), .busy(busy)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        flt;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          stall;
    int          delay;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    wbstall_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_phase = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: field size and signedness from funct3, then plain mask arithmetic.
  function automatic void model(input logic [63:0] a, input logic [2:0] f, input logic [63:0] d,
                                output logic [63:0] r, output logic flt);
    int bits;
    bit sgn;
    logic [63:0] s, mask;
    s = d >> (8 * a[2:0]);
    case (f)
      3'd0: begin bits = 8;  sgn = 1; end
      3'd1: begin bits = 16; sgn = 1; end
      3'd2: begin bits = 32; sgn = 1; end
      3'd4: begin bits = 8;  sgn = 0; end
      3'd5: begin bits = 16; sgn = 0; end
      3'd6: begin bits = 32; sgn = 0; end
      default: begin bits = 64; sgn = 0; end
    endcase
    flt = 1'b0;
`ifdef YSYX_22050243_LOAD_ALIGN_CHECK_EN
    if (bits == 64) flt = (f == 3'd7) || (a % 8 != 0);
    else if (bits > 8) flt = (a % (bits / 8)) != 0;
`endif
    if (flt) r = '0;
    else if (bits == 64) r = s;
    else begin
      mask = (64'd1 << bits) - 64'd1;
      r = s & mask;
      if (sgn && r[bits-1]) r = r | ~mask;
    end
  endfunction

  task automatic idle(input int n);
    ld_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance with ld_valid still high.
  task automatic issue(input logic [63:0] a, input logic [2:0] f, input logic [4:0] rd,
                       input logic [63:0] d, input int n, input int dl, input int w);
    exp_t e;
    plan_t p;
    logic [63:0] r;
    logic flt;
    int t;
    ld_valid = 1; ld_addr = a; ld_funct3 = f; ld_rd = rd;
    t = 0;
    @(negedge clk);
    while (!ld_ready && t < 200) begin @(negedge clk); t++; end
    if (!ld_ready) begin
      check("accept_timeout", ld_ready, 1);
      ld_valid = 0;
      return;
    end
    model(a, f, d, r, flt);
    e.data = r; e.rd = rd; e.flt = flt; e.acc = cyc; e.lat = flt ? 1 : 3 + n + dl;
    exp_q.push_back(e);
    if (!flt) begin
      p.addr = a & ~64'h7; p.data = d; p.stall = n; p.delay = dl;
      plan_q.push_back(p);
    end
    wbstall_q.push_back(w);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check("rst_ld_ready", ld_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_fault", wb_fault, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
  endtask

  // Memory model: scripted request stall and response delay per load, plus stray responses when idle.
  initial begin
    plan_t cur;
    int stall, rcnt;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    stall = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("req_valid", mem_req_valid, rsp_phase == 1);
        if (rsp_phase == 1) begin
          check("req_addr", mem_req_addr, cur.addr);
          if (mem_req_valid && mem_req_ready) begin
            rsp_phase = 2;
            rcnt = cur.delay;
          end
        end
      end
      @(posedge clk); #1;
      mem_resp_valid = 0;
      mem_resp_data = {$urandom, $urandom};
      if (rsp_phase == 2) begin
        if (rcnt == 0) begin
          mem_resp_valid = 1;
          mem_resp_data = cur.data;
          rsp_phase = 0;
        end else rcnt--;
      end else if (rsp_phase == 1) begin
        if (stall > 0) stall--;
      end else if (plan_q.size() > 0) begin
        cur = plan_q.pop_front();
        rsp_phase = 1;
        stall = cur.stall;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_resp_valid = 1;
      end
      mem_req_ready = (rsp_phase == 1) ? (stall == 0) : 1'($urandom_range(0, 1));
    end
  end

  // Writeback sink: holds wb_ready low for the scripted number of cycles once wb_valid rises.
  initial begin
    bit sink_active;
    int scnt;
    wb_ready = 0; sink_active = 0; scnt = 0;
    forever begin
      @(posedge clk); #1;
      if (sink_active && wb_ready) sink_active = 0;
      if (!sink_active && wb_valid) begin
        sink_active = 1;
        scnt = (wbstall_q.size() > 0) ? wbstall_q.pop_front() : 0;
      end
      if (sink_active) begin
        wb_ready = (scnt == 0);
        if (scnt > 0) scnt--;
      end else wb_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake protocol, latency and result checks against the scoreboard.
  initial begin
    bit outstanding, prev_v;
    exp_t e;
    outstanding = 0; prev_v = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        outstanding = 0;
        prev_v = 0;
      end else begin
        check("ld_ready", ld_ready, !outstanding);
        check("busy", busy, outstanding);
        if (exp_q.size() == 0) check("wb_valid_idle", wb_valid, 0);
        else if (wb_valid) begin
          e = exp_q[0];
          if (!prev_v) check("latency", cyc - e.acc, e.lat);
          check("wb_data", wb_data, e.data);
          check("wb_rd", wb_rd, e.rd);
          check("wb_fault", wb_fault, e.flt);
          if (wb_ready) begin
            e = exp_q.pop_front();
            outstanding = 0;
          end
        end
        if (ld_valid && ld_ready) outstanding = 1;
        prev_v = wb_valid;
      end
    end
  end

  initial begin
    int t;
    rst = 1; ld_valid = 0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;

    issue(64'h8000_0005, 3'b000, 5'd5, 64'h0011_8000_0000_0000, 0, 0, 0);
    idle(2);
    issue(64'h8000_0004, 3'b110, 5'd6, 64'hDEAD_BEEF_0000_0000, 0, 0, 0);
    idle(1);
    issue(64'h8000_0004, 3'b010, 5'd7, 64'hDEAD_BEEF_0000_0000, 1, 0, 1);
    idle(1);
    issue(64'h8000_0008, 3'b011, 5'd8, 64'h0123_4567_89AB_CDEF, 3, 1, 2);
    idle(1);
    issue(64'h8000_0003, 3'b001, 5'd10, 64'h0000_0012_8000_0000, 0, 0, 0);
    idle(1);
    issue(64'h8000_0006, 3'b010, 5'd11, 64'h8765_0000_0000_0000, 0, 2, 0);
    idle(1);
    issue(64'h8000_0000, 3'b111, 5'd12, 64'hF0E1_D2C3_B4A5_9687, 0, 0, 0);
    idle(3);

    // Reset while waiting for the response; the late response must not surface.
    issue(64'h8000_0010, 3'b011, 5'd9, 64'h1234_5678_9ABC_DEF0, 0, 6, 0);
    ld_valid = 0;
    t = 0;
    while (rsp_phase != 2 && t < 50) begin @(negedge clk); t++; end
    check("reset_test_handshake", rsp_phase, 2);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    wbstall_q.delete();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      issue(64'h8000_0000 + 64'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 5'($urandom),
            {$urandom, $urandom}, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    idle(2);

    for (int i = 0; i < 150; i++) begin
      issue({$urandom, $urandom}, 3'($urandom_range(0, 7)), 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    check("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
